// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: protocol prefix bytes,
// 7-segment glyphs and the built-in scancode (set 2) to ASCII table.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int unsigned PS2_TIMEOUT_CYCLES_DEFAULT = 100000;

  // Bits [7:1] = segments a..g active-low, bit 0 = dp (kept off).
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_LUT [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  // Scancode to ASCII ROM contents: lowercase letters, digits, space, Enter.
  function automatic logic [7:0] scan2ascii(input logic [7:0] sc);
    case (sc)
      8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
      8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
      8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
      8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
      8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
      8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
      8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
      8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
      8'h35: return 8'h79;  8'h1A: return 8'h7A;
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h29: return 8'h20;  8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_kbd_scan_display_if.sv
// Board-facing signal bundle of ps2_kbd_scan_display: PS/2 pins in,
// decoded key data and seven-segment digits out.
interface ps2_kbd_scan_display_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic [7:0] asciicode;
  logic [7:0] count;
  logic       ready;
  logic       overflow;
  logic       frame_err;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  // Board / stimulus side: drives the PS/2 pins, observes results.
  modport master (
    output ps2_clk, ps2_data,
    input  scancode, asciicode, count, ready, overflow, frame_err,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  // Keyboard front end side.
  modport slave (
    input  ps2_clk, ps2_data,
    output scancode, asciicode, count, ready, overflow, frame_err,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/ps2_kbd_scan_display_hex7seg.sv
// One hexadecimal digit to active-low 7-segment pattern (dp off).
module hex7seg
  import ps2_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);
  assign seg_o = SEG_LUT[nib_i];
endmodule

// File: rtl/ps2_kbd_scan_display.sv
// PS/2 keyboard front end: frame receiver with timeout, make/break/extended
// decoder with typematic filtering, scancode->ASCII ROM and six hex digits.
// The ROM contents are built into ps2_pkg::scan2ascii.
// Optional feature macro: PS2_BLANK_ON_RELEASE_EN blanks HEX0-HEX3 after the
// held key is released, until the next make code.
module ps2_kbd_scan_display
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  ps2_kbd_scan_display_if.slave   bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       ps2c_sync_q, ps2d_sync_q;
  logic             ps2c_prev_q;
  logic             fall;
  logic [10:0]      shreg_q, shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             done_q, done_d;
  logic             frame_ok, frame_bad;
  logic [7:0]       rx_byte;
  logic [7:0]       scancode_q, scancode_d, asciicode_q;
  logic [7:0]       count_q, count_d, held_q, held_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic             overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic             blank;
`ifdef PS2_BLANK_ON_RELEASE_EN
  logic             blank_q, blank_d;
`endif

  // Synchronise the asynchronous PS/2 pins; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
      ps2c_prev_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      ps2c_sync_q <= {ps2c_sync_q[0], bus.ps2_clk};
      ps2d_sync_q <= {ps2d_sync_q[0], bus.ps2_data};
      ps2c_prev_q <= ps2c_sync_q[1];
    end
  end

  assign fall = ps2c_prev_q & ~ps2c_sync_q[1];

  // Shift bits in on falling edges; drop a partial frame after a long silence.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = '0;
    done_d    = 1'b0;
    if (fall) begin
      shreg_d = {ps2d_sync_q[1], shreg_q[10:1]};
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        done_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == TMO_LAST) bit_cnt_d = 4'd0;
      else                   tmo_d     = tmo_q + 1'b1;
    end
  end

  // Frame check: start 0, stop 1, odd parity over data + parity bit.
  assign rx_byte   = shreg_q[8:1];
  assign frame_ok  = done_q & ~shreg_q[0] & shreg_q[10] & (^shreg_q[9:1]);
  assign frame_bad = done_q & ~frame_ok;

  // Byte decoder: prefixes, releases, make codes with typematic filtering.
  always_comb begin
    scancode_d  = scancode_q;
    count_d     = count_q;
    held_d      = held_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q | frame_bad;
`ifdef PS2_BLANK_ON_RELEASE_EN
    blank_d     = blank_q;
`endif
    if (frame_ok) begin
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        if (rx_byte == held_q) begin
          held_d = 8'h00;
`ifdef PS2_BLANK_ON_RELEASE_EN
          blank_d = 1'b1;
`endif
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        scancode_d = rx_byte;
        if (rx_byte != held_q) begin
          count_d = count_q + 8'd1;
          held_d  = rx_byte;
          if (count_q == 8'hFF) overflow_d = 1'b1;
        end
        ext_d = 1'b0;
`ifdef PS2_BLANK_ON_RELEASE_EN
        blank_d = 1'b0;
`endif
      end
    end
  end

  // Receiver, decoder and ROM output registers; reset wins over all updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      scancode_q  <= '0;
      asciicode_q <= '0;
      count_q     <= '0;
      held_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_BLANK_ON_RELEASE_EN
      blank_q     <= 1'b0;
`endif
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      scancode_q  <= scancode_d;
      asciicode_q <= scan2ascii(scancode_q);
      count_q     <= count_d;
      held_q      <= held_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_BLANK_ON_RELEASE_EN
      blank_q     <= blank_d;
`endif
    end
  end

`ifdef PS2_BLANK_ON_RELEASE_EN
  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  logic [3:0] nib [6];
  logic [7:0] seg [6];

  assign nib[0] = scancode_q[3:0];
  assign nib[1] = scancode_q[7:4];
  assign nib[2] = asciicode_q[3:0];
  assign nib[3] = asciicode_q[7:4];
  assign nib[4] = count_q[3:0];
  assign nib[5] = count_q[7:4];

  for (genvar g = 0; g < 6; g++) begin : g_hex
    hex7seg u_hex (.nib_i(nib[g]), .seg_o(seg[g]));
  end

  assign bus.scancode  = scancode_q;
  assign bus.asciicode = asciicode_q;
  assign bus.count     = count_q;
  assign bus.ready     = frame_ok;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;
  assign bus.HEX0      = blank ? SEG_BLANK : seg[0];
  assign bus.HEX1      = blank ? SEG_BLANK : seg[1];
  assign bus.HEX2      = blank ? SEG_BLANK : seg[2];
  assign bus.HEX3      = blank ? SEG_BLANK : seg[3];
  assign bus.HEX4      = seg[4];
  assign bus.HEX5      = seg[5];

endmodule

// File: tb/tb_ps2_kbd_scan_display.sv
// Directed bench for ps2_kbd_scan_display: reset, make/break, typematic,
// parity error, timeout recovery, extended prefix and count wrap.
module tb_ps2_kbd_scan_display;

  localparam int unsigned TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   ready_cnt = 0;
  int   r0;

  ps2_kbd_scan_display_if bus ();

  ps2_kbd_scan_display #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count ready pulses, sampled away from the active edge.
  always @(negedge clk) if (bus.ready === 1'b1) ready_cnt <= ready_cnt + 1;

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'h03; 4'h1: return 8'h9F; 4'h2: return 8'h25; 4'h3: return 8'h0D;
      4'h4: return 8'h99; 4'h5: return 8'h49; 4'h6: return 8'h41; 4'h7: return 8'h1F;
      4'h8: return 8'h01; 4'h9: return 8'h09; 4'hA: return 8'h11; 4'hB: return 8'hC1;
      4'hC: return 8'h63; 4'hD: return 8'h85; 4'hE: return 8'h61; default: return 8'h71;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic good_parity = 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(good_parity ? ~^b : ^b);
    ps2_bit(1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;

    // Reset then idle: everything zero, every digit shows 0.
    do_reset();
    repeat (20) @(negedge clk);
    check("rst_scancode", bus.scancode, 8'h00);
    check("rst_ascii", bus.asciicode, 8'h00);
    check("rst_count", bus.count, 8'h00);
    check("rst_ready", {7'd0, bus.ready}, 8'h00);
    check("rst_flags", {6'd0, bus.overflow, bus.frame_err}, 8'h00);
    check("rst_hex0", bus.HEX0, 8'h03);
    check("rst_hex3", bus.HEX3, 8'h03);
    check("rst_hex5", bus.HEX5, 8'h03);

    // Press and release 'a'.
    r0 = ready_cnt;
    send(8'h1C);
    check("a_scancode", bus.scancode, 8'h1C);
    check("a_ascii", bus.asciicode, 8'h61);
    check("a_count", bus.count, 8'h01);
    check("a_hex1", bus.HEX1, seg(4'h1));
    check("a_hex0", bus.HEX0, seg(4'hC));
    send(8'hF0);
    send(8'h1C);
    check("a_ready3", 8'(ready_cnt - r0), 8'd3);
    check("a_rel_scancode", bus.scancode, 8'h1C);
    check("a_rel_count", bus.count, 8'h01);
    check("a_hex5", bus.HEX5, seg(4'h0));
    check("a_hex4", bus.HEX4, seg(4'h1));
`ifdef PS2_BLANK_ON_RELEASE_EN
    check("a_hex3_blank", bus.HEX3, 8'hFF);
    check("a_hex0_blank", bus.HEX0, 8'hFF);
`else
    check("a_hex3", bus.HEX3, seg(4'h6));
    check("a_hex2", bus.HEX2, seg(4'h1));
`endif

    // Typematic repeats counted once; a fresh press counts again.
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    check("typ_count", bus.count, 8'h01);
    send(8'hF0); send(8'h1C);
    check("typ_rel_count", bus.count, 8'h01);
    send(8'h1C);
    check("typ_fresh_count", bus.count, 8'h02);
    check("typ_hex0", bus.HEX0, seg(4'hC));

    // Bad parity: sticky error, no ready, no state change.
    r0 = ready_cnt;
    send(8'h32, 1'b0);
    check("par_err", {7'd0, bus.frame_err}, 8'h01);
    check("par_ready", 8'(ready_cnt - r0), 8'd0);
    check("par_scancode", bus.scancode, 8'h1C);
    check("par_count", bus.count, 8'h02);

    // Partial frame abandoned by timeout, then a clean '1'.
    do_reset();
    for (int i = 0; i < 6; i++) ps2_bit(i[0]);
    repeat (TMO + 50) @(negedge clk);
    send(8'h16);
    check("tmo_scancode", bus.scancode, 8'h16);
    check("tmo_ascii", bus.asciicode, 8'h31);
    check("tmo_frame_err", {7'd0, bus.frame_err}, 8'h00);
    check("tmo_count", bus.count, 8'h01);

    // Extended prefix does not disturb the make code path.
    r0 = ready_cnt;
    send(8'hE0); send(8'h75);
    check("ext_scancode", bus.scancode, 8'h75);
    check("ext_ascii", bus.asciicode, 8'h00);
    check("ext_count", bus.count, 8'h02);
    check("ext_ready", 8'(ready_cnt - r0), 8'd2);

    // 256 press/release pairs wrap the counter and set overflow.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      send(i[0] ? 8'h45 : 8'h29);
      send(8'hF0);
      send(i[0] ? 8'h45 : 8'h29);
    end
    check("wrap_pre_count", bus.count, 8'hFF);
    check("wrap_pre_ovf", {7'd0, bus.overflow}, 8'h00);
    send(8'h45);
    check("wrap_count", bus.count, 8'h00);
    check("wrap_ovf", {7'd0, bus.overflow}, 8'h01);
    check("wrap_ascii", bus.asciicode, 8'h30);
    send(8'hF0); send(8'h45); send(8'h5A);
    check("wrap_post_count", bus.count, 8'h01);
    check("wrap_ovf_sticky", {7'd0, bus.overflow}, 8'h01);
    check("enter_ascii", bus.asciicode, 8'h0D);
    do_reset();
    check("ovf_cleared", {7'd0, bus.overflow}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
